// File: rtl/arbiter_pkg.sv
// Shared types and helpers for multiply_arbiter.
//   tag_t        : requester index carried through the tag FIFO (supports N up to MAX_N)
//   lock_state_t : issue-side lock state
//   rr_next      : round-robin search, first valid index at or above ptr, modulo n
package arbiter_pkg;

  localparam int MAX_N = 16;
  localparam int TAG_W = $clog2(MAX_N);

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  // Walks offsets from the highest down so the smallest offset from ptr wins.
  // If nothing is valid the result is ptr; the caller ignores it in that case.
  function automatic tag_t rr_next(input tag_t ptr, input logic [MAX_N-1:0] valid, input int n);
    int   sum;
    tag_t idx;
    rr_next = ptr;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        sum = int'(ptr) + k;
        if (sum >= n) sum = sum - n;
        idx = tag_t'(sum);
        if (valid[idx]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/multiply_arbiter_if.sv
// Bundle of all requester-side and multiplier-side stream signals of multiply_arbiter.
//   s_*      : per-requester operand streams (requester -> arbiter)
//   m_*      : per-requester product streams (arbiter -> requester)
//   mul_s_*  : operand stream to the shared multiplier
//   mul_m_*  : product stream from the shared multiplier
//   err      : sticky "result with no owner" flag
// Modport slave is the arbiter's view, master is the surrounding environment.
interface multiply_arbiter_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic [N-1:0]                s_valid;
  logic [N-1:0]                s_ready;
  logic [N-1:0][1:0][W-1:0]    s_data;
  logic [N-1:0]                m_valid;
  logic [N-1:0]                m_ready;
  logic [N-1:0][2*W-1:0]       m_data;
  logic                        mul_s_valid;
  logic                        mul_s_ready;
  logic [1:0][W-1:0]           mul_s_data;
  logic                        mul_m_valid;
  logic                        mul_m_ready;
  logic [2*W-1:0]              mul_m_data;
  logic                        err;

  modport slave (
    input  s_valid, s_data, m_ready, mul_s_ready, mul_m_valid, mul_m_data,
    output s_ready, m_valid, m_data, mul_s_valid, mul_s_data, mul_m_ready, err
  );

  modport master (
    output s_valid, s_data, m_ready, mul_s_ready, mul_m_valid, mul_m_data,
    input  s_ready, m_valid, m_data, mul_s_valid, mul_s_data, mul_m_ready, err
  );
endinterface

// File: rtl/multiply_arbiter_tag_fifo.sv
// tag_fifo: register-based FIFO holding the owner tag of every in-flight product.
//   push/din : enqueue din (ignored while full, even if popping the same cycle)
//   pop      : dequeue oldest entry (ignored while empty)
//   full, empty, head : occupancy flags and oldest entry
module tag_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multiply_arbiter.sv
// multiply_arbiter: shares one multiplier among N requesters.
// Round-robin picks a requester, its operand pair goes straight to mul_s_*,
// and its index is queued in a tag FIFO so the in-order result on mul_m_*
// can be steered back to the right m_* lane. Both paths are combinational.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : multiply_arbiter_if.slave (all stream signals and err)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_OPEN   | grant follows the round-robin search every cycle
//   ST_LOCKED | an offered pair was stalled by mul_s_ready; grant is held
//             | in lock_grant until that pair is accepted
module multiply_arbiter
  import arbiter_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  parameter int D = 4
) (
  input logic                clk,
  input logic                rst,
  multiply_arbiter_if.slave  bus
);

  lock_state_t       state_q, state_d;
  tag_t              ptr, lock_grant, grant_rr, grant, head;
  logic [MAX_N-1:0]  valid_ext;
  logic [1:0][W-1:0] sel_data;
  logic              sel_valid, head_ready;
  logic              full, empty, active;
  logic              mul_s_valid_int, mul_m_ready_int;
  logic              issue, ret;
  logic              err_q;

  // Outputs are held low while rst is asserted, not just after the first edge.
  assign active    = ~rst;
  assign valid_ext = MAX_N'(bus.s_valid);
  assign grant_rr  = rr_next(ptr, valid_ext, N);
  assign grant     = (state_q == ST_LOCKED) ? lock_grant : grant_rr;

  always_comb begin
    sel_valid  = 1'b0;
    sel_data   = '0;
    head_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant == tag_t'(i)) begin
        sel_valid = bus.s_valid[i];
        sel_data  = bus.s_data[i];
      end
      if (head == tag_t'(i)) head_ready = bus.m_ready[i];
    end
  end

  assign mul_s_valid_int = active & sel_valid & ~full;
  assign mul_m_ready_int = active & head_ready & ~empty;
  assign issue           = mul_s_valid_int & bus.mul_s_ready;
  assign ret             = bus.mul_m_valid & mul_m_ready_int;

  assign bus.mul_s_valid = mul_s_valid_int;
  assign bus.mul_s_data  = sel_data;
  assign bus.mul_m_ready = mul_m_ready_int;
  assign bus.err         = err_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.s_ready[i] = active & (grant == tag_t'(i)) & bus.mul_s_ready & ~full;
      bus.m_valid[i] = active & (head == tag_t'(i)) & bus.mul_m_valid & ~empty;
      bus.m_data[i]  = bus.mul_m_data;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_OPEN) begin
      if (mul_s_valid_int && !bus.mul_s_ready) state_d = ST_LOCKED;
    end else begin
      if (issue) state_d = ST_OPEN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OPEN;
      ptr        <= '0;
      lock_grant <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_OPEN && state_d == ST_LOCKED) lock_grant <= grant;
      if (issue) ptr <= (grant == tag_t'(N - 1)) ? '0 : grant + tag_t'(1);
      // A result with no recorded owner means the multiplier and tag FIFO disagree.
      if (bus.mul_m_valid && empty) err_q <= 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (D)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (grant),
    .pop   (ret),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

endmodule

// File: doc/multiply_arbiter.md
# multiply_arbiter

Shares one `multiply` instance between N requesters. Each requester presents a signed operand pair on its own stream slave port. The block selects requesters round-robin and forwards the chosen pair to the multiplier's `s_` port. It tracks which requester owns each in-flight product in a tag FIFO and steers each `m_` result back to that requester's stream master port. The block sits between per-neuron/per-lane producers and the shared datapath and adds zero cycles to the multiply path.

## Interface
- `W`, 8: operand width; products are 2*W, signed two's complement.
- `N`, 4: number of requesters, N ≥ 2.
- `D`, 4: tag FIFO depth (max products in flight), D ≥ 1.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `s_valid` input N: requester i has an operand pair.
- `s_ready` output N: operand pair of requester i accepted.
- `s_data` input N×2×W: operand pair per requester, [i][0] and [i][1].
- `m_valid` output N: product available for requester i.
- `m_ready` input N: requester i accepts product.
- `m_data` output N×2*W: product per requester; all lanes carry the same `mul_m_data`.
- `mul_s_valid`, `mul_s_ready`, `mul_s_data` (1, 1, 2×W): stream master to multiplier `s_`.
- `mul_m_valid`, `mul_m_ready`, `mul_m_data` (1, 1, 2*W): stream slave from multiplier `m_`.
- `err` output 1: sticky; set when `mul_m_valid` is high while the tag FIFO is empty.

## Operation
- Handshake: a transfer occurs on a cycle where valid and ready are both high. Once valid is asserted, data is held until the transfer completes.
- Arbitration:
  - Register `ptr` (clog2 N bits) holds round-robin priority.
  - When unlocked, `grant` is the first i with `s_valid[i]`, searching from `ptr` upward modulo N.
- Issue:
  - `mul_s_valid = s_valid[grant] & !full`.
  - `mul_s_data = s_data[grant]`.
  - `s_ready[grant] = mul_s_ready & !full`; all other `s_ready` bits are 0.
- Lock: if `mul_s_valid & !mul_s_ready`, set `lock` and hold `grant` in a register. While locked, grant does not change even if other requesters become valid.
- On issue handshake:
  - Push `grant` into the tag FIFO.
  - Set `ptr` to `grant+1` mod N.
  - Clear `lock`.
- Return:
  - `head` = oldest tag.
  - `m_valid[head] = mul_m_valid & !empty`; all other `m_valid` bits are 0.
  - `mul_m_ready = m_ready[head] & !empty`.
  - On return handshake, pop the FIFO.
- The multiplier returns results in order, so head always matches the current result.
- Full: push is blocked while full, even if a pop occurs the same cycle. Simultaneous push and pop when not full or empty are permitted; count is unchanged.
- Empty: `mul_m_ready = 0`. If `mul_m_valid = 1` while empty, set `err`; `err` clears only on reset.
- Head-of-line blocking is required: a stalled `m_ready[head]` stalls all later results.

## Timing
- Reset values:
  - Outputs: `s_ready`, `m_valid`, `mul_s_valid`, `mul_m_ready` and `err` are all 0.
  - Internal state: `ptr = 0`, `lock = 0`, FIFO empty.
- Reset asserted mid-operation discards all in-flight tags. The multiplier shares `rst`, so no stale result survives.
- Issue and return paths are combinational: 0 added cycles. End-to-end latency equals the multiplier latency.
- Throughput: one issue per cycle when `mul_s_ready` is high and the FIFO is not full. Sustained rate with continuous requests is 1/cycle, provided D ≥ multiplier pipeline depth + 1.
- Fairness: with all N valid and no backpressure, grants rotate 0,1,…,N-1,0, one per cycle.

## Structure
- Shared package `arbiter_pkg`:
  - `tag_t` (clog2 N bits);
  - function `rr_next(ptr, valid)` for the round-robin search.
- Sub-module `tag_fifo`:
  - parameters: width, depth D;
  - ports: push, pop, full, empty, head;
  - register-based storage with wrap-around pointers and an occupancy counter of clog2(D+1) bits.
- The arbitration logic and lock register live in the top module.

## Test plan
All scenarios use W=8, N=3, D=2 and the real `multiply`.
- Single request: requester 1 sends (8'h03, 8'hFE) → `m_valid[1]` with `m_data = 16'hFFFA`. `m_valid[0]` and `m_valid[2]` stay 0 throughout.
- Round-robin: all three hold random valid pairs for 6 issues → grant order is 0,1,2,0,1,2. Each product equals the signed product and arrives at its originator.
- Lock: hold `mul_s_ready = 0` for 5 cycles while requester 2 is granted, then raise `s_valid[0]` → grant stays 2. `s_data[2]` is the issued pair on release.
- Full and head-of-line: hold `m_ready[0] = 0` after issuing for requesters 0 and 1 → `s_ready` stays 0 for all requesters (FIFO full). Releasing `m_ready[0]` delivers the 0 result, then the 1 result.
- Reset mid-operation: assert `rst` with 2 products in flight → all outputs 0 immediately, `ptr = 0`. The next request from requester 2 completes correctly.
- Error: force `mul_m_valid = 1` with the FIFO empty → `err = 1` next cycle and it stays 1 until `rst`.
